// File: rtl/ysyx_23060203_pkg.sv
// rtl/ysyx_23060203_pkg.sv - shared encodings for the ysyx_23060203 decode stage
package ysyx_23060203_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_LTS = 3'b010;
  localparam logic [2:0] ALU_LTU = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // One decoded instruction as held in the output register.
  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  funct;
    logic        funcs;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [1:0]  wb_sel;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  mem_size;
    logic        br_en;
    logic [2:0]  br_cond;
    logic        jump;
    logic        jalr;
    logic        illegal;
  } idu_entry_t;

  // Register/immediate ALU ops reuse funct3 directly; spelled out so the
  // ALU encoding lives in exactly one place.
  function automatic logic [2:0] alu_op_of(input logic [2:0] f3);
    logic [2:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SHL;
      3'b010:  op = ALU_LTS;
      3'b011:  op = ALU_LTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SHR;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx_23060203_imm_gen.sv
// rtl/ysyx_23060203_imm_gen.sv - sign-extended immediate extraction by opcode
module ysyx_23060203_imm_gen
  import ysyx_23060203_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  // Pick the immediate format implied by the opcode; R-type and unknown give 0.
  always_comb begin
    imm = '0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060203_idu.sv
// rtl/ysyx_23060203_idu.sv - RV32I decode stage with one-entry output register
module ysyx_23060203_idu
  import ysyx_23060203_pkg::*;
(
  input  logic        clock,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_alu_a,
  output logic [31:0] out_alu_b,
  output logic [2:0]  out_funct,
  output logic        out_funcs,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [31:0] out_rs2_val,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic [1:0]  out_wb_sel,
  output logic        out_mem_ren,
  output logic        out_mem_wen,
  output logic [2:0]  out_mem_size,
  output logic        out_br_en,
  output logic [2:0]  out_br_cond,
  output logic        out_jump,
  output logic        out_jalr,
  output logic        out_illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        wr;
  logic        accept;
  idu_entry_t  dec;
  idu_entry_t  entry_d, entry_q;
  logic        valid_d, valid_q;

  assign opcode    = in_inst[6:0];
  assign f3        = in_inst[14:12];
  assign f7        = in_inst[31:25];
  assign rd        = in_inst[11:7];
  assign rf_raddr1 = in_inst[19:15];
  assign rf_raddr2 = in_inst[24:20];

  ysyx_23060203_imm_gen u_imm_gen (
    .inst (in_inst),
    .imm  (imm)
  );

  // Decode the presented instruction into an entry; illegal ones keep their
  // operands but have every side-effecting enable cleared.
  always_comb begin
    dec         = '0;
    wr          = 1'b0;
    dec.alu_a   = rf_rdata1;
    dec.alu_b   = imm;
    dec.funct   = ALU_ADD;
    dec.funcs   = 1'b0;
    dec.pc      = in_pc;
    dec.imm     = imm;
    dec.rs2_val = rf_rdata2;
    dec.rd      = rd;
    case (opcode)
      OPC_OP: begin
        dec.alu_b = rf_rdata2;
        dec.funct = alu_op_of(f3);
        wr        = 1'b1;
        if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) dec.funcs = 1'b1;
        else if (f7 != 7'b0000000) dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.funct = alu_op_of(f3);
        wr        = 1'b1;
        if (f3 == 3'b001) begin
          dec.illegal = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          if (f7 == 7'b0100000) dec.funcs = 1'b1;
          else if (f7 != 7'b0000000) dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.alu_a = '0;
        wr        = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_a = in_pc;
        wr        = 1'b1;
      end
      OPC_LOAD: begin
        dec.mem_ren  = 1'b1;
        dec.mem_size = f3;
        dec.wb_sel   = WB_MEM;
        wr           = 1'b1;
        dec.illegal  = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.mem_wen  = 1'b1;
        dec.mem_size = f3;
        dec.illegal  = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec.alu_b   = rf_rdata2;
        dec.br_en   = 1'b1;
        dec.br_cond = f3;
        case (f3[2:1])
          2'b00: dec.funcs   = 1'b1;
          2'b01: dec.illegal = 1'b1;
          2'b10: dec.funct   = ALU_LTS;
          default: dec.funct = ALU_LTU;
        endcase
      end
      OPC_JAL: begin
        dec.alu_a  = in_pc;
        dec.jump   = 1'b1;
        dec.wb_sel = WB_PC4;
        wr         = 1'b1;
      end
      OPC_JALR: begin
        dec.jump    = 1'b1;
        dec.jalr    = 1'b1;
        dec.wb_sel  = WB_PC4;
        wr          = 1'b1;
        dec.illegal = (f3 != 3'b000);
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rd_wen = wr && (rd != 5'd0);
    if (dec.illegal) begin
      dec.rd_wen  = 1'b0;
      dec.mem_ren = 1'b0;
      dec.mem_wen = 1'b0;
      dec.br_en   = 1'b0;
      dec.jump    = 1'b0;
    end
  end

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Output register next state: flush kills, accept loads, drain empties.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      entry_d = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_alu_a    = entry_q.alu_a;
  assign out_alu_b    = entry_q.alu_b;
  assign out_funct    = entry_q.funct;
  assign out_funcs    = entry_q.funcs;
  assign out_pc       = entry_q.pc;
  assign out_imm      = entry_q.imm;
  assign out_rs2_val  = entry_q.rs2_val;
  assign out_rd       = entry_q.rd;
  assign out_rd_wen   = entry_q.rd_wen;
  assign out_wb_sel   = entry_q.wb_sel;
  assign out_mem_ren  = entry_q.mem_ren;
  assign out_mem_wen  = entry_q.mem_wen;
  assign out_mem_size = entry_q.mem_size;
  assign out_br_en    = entry_q.br_en;
  assign out_br_cond  = entry_q.br_cond;
  assign out_jump     = entry_q.jump;
  assign out_jalr     = entry_q.jalr;
  assign out_illegal  = entry_q.illegal;

endmodule

// File: tb/tb_ysyx_23060203_idu.sv
// tb/tb_ysyx_23060203_idu.sv - vector-table bench for the decode stage
module tb_ysyx_23060203_idu;

  logic        clock = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_a, out_alu_b;
  logic [2:0]  out_funct;
  logic        out_funcs;
  logic [31:0] out_pc, out_imm, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [1:0]  out_wb_sel;
  logic        out_mem_ren, out_mem_wen;
  logic [2:0]  out_mem_size;
  logic        out_br_en;
  logic [2:0]  out_br_cond;
  logic        out_jump, out_jalr, out_illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  ysyx_23060203_idu dut (
    .clock(clock), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
    .out_funct(out_funct), .out_funcs(out_funcs),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_wb_sel(out_wb_sel),
    .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen), .out_mem_size(out_mem_size),
    .out_br_en(out_br_en), .out_br_cond(out_br_cond),
    .out_jump(out_jump), .out_jalr(out_jalr), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] inst, pc, r1, r2, a, b, imm;
    logic [4:0]  rd;
    logic [2:0]  funct;
    logic        funcs, wen;
    logic [1:0]  wb;
    logic        mren, mwen;
    logic [2:0]  msize;
    logic        br;
    logic [2:0]  cond;
    logic        jump, jalr, ill;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic [31:0] inst, pc, r1, r2, a, b, imm,
    input logic [4:0] rd, input logic [2:0] funct, input logic funcs, wen,
    input logic [1:0] wb, input logic mren, mwen, input logic [2:0] msize,
    input logic br, input logic [2:0] cond, input logic jump, jalr, ill);
    vec_t v;
    v.inst = inst; v.pc = pc; v.r1 = r1; v.r2 = r2; v.a = a; v.b = b; v.imm = imm;
    v.rd = rd; v.funct = funct; v.funcs = funcs; v.wen = wen; v.wb = wb;
    v.mren = mren; v.mwen = mwen; v.msize = msize; v.br = br; v.cond = cond;
    v.jump = jump; v.jalr = jalr; v.ill = ill;
    return v;
  endfunction

  function automatic logic [31:0] ctrl_word(
    input logic [4:0] rd, input logic [2:0] funct, input logic funcs, wen,
    input logic [1:0] wb, input logic mren, mwen, input logic [2:0] msize,
    input logic br, input logic [2:0] cond, input logic jump, jalr, ill);
    return {8'b0, rd, funct, funcs, wen, wb, mren, mwen, msize, br, cond, jump, jalr, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_ctrl();
    return ctrl_word(out_rd, out_funct, out_funcs, out_rd_wen, out_wb_sel, out_mem_ren,
                     out_mem_wen, out_mem_size, out_br_en, out_br_cond, out_jump,
                     out_jalr, out_illegal);
  endfunction

  task automatic drive(input vec_t v);
    in_inst = v.inst; in_pc = v.pc; rf_rdata1 = v.r1; rf_rdata2 = v.r2;
  endtask

  task automatic check_entry(input vec_t v, input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_alu_a"}, out_alu_a, v.a);
    check({tag, "_alu_b"}, out_alu_b, v.b);
    check({tag, "_imm"}, out_imm, v.imm);
    check({tag, "_pc"}, out_pc, v.pc);
    check({tag, "_rs2_val"}, out_rs2_val, v.r2);
    check({tag, "_ctrl"}, dut_ctrl(),
          ctrl_word(v.rd, v.funct, v.funcs, v.wen, v.wb, v.mren, v.mwen, v.msize,
                    v.br, v.cond, v.jump, v.jalr, v.ill));
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clock);
    drive(v);
    in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_raddr1"}, 32'(rf_raddr1), 32'(v.inst[19:15]));
    check({tag, "_raddr2"}, 32'(rf_raddr2), 32'(v.inst[24:20]));
    @(posedge clock);
    #1;
    check_entry(v, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          inst          pc            r1            r2            a             b             imm           rd f     s  w  wb m  m  sz br cond j  jr il
    vecs[0]  = mk(32'hC0010093, 32'h80000000, 32'd5,        32'h77,       32'd5,        32'hFFFFFC00, 32'hFFFFFC00, 1, 3'd0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    vecs[1]  = mk(32'h402081B3, 32'h80000004, 32'd10,       32'd3,        32'd10,       32'd3,        32'd0,        3, 3'd0, 1, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    vecs[2]  = mk(32'h40335293, 32'h80000008, 32'hF0000000, 32'd9,        32'hF0000000, 32'h403,      32'h403,      5, 3'd5, 1, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    vecs[3]  = mk(32'h00208463, 32'h8000000C, 32'd7,        32'd7,        32'd7,        32'd7,        32'd8,        8, 3'd0, 1, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0);
    vecs[4]  = mk(32'h0020E463, 32'h80000010, 32'd1,        32'd2,        32'd1,        32'd2,        32'd8,        8, 3'd3, 0, 0, 0, 0, 0, 0, 1, 3'd6, 0, 0, 0);
    vecs[5]  = mk(32'h00000000, 32'h80000014, 32'h11,       32'h22,       32'h11,       32'd0,        32'd0,        0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1);
    vecs[6]  = mk(32'h4000A0B3, 32'h80000018, 32'h33,       32'h44,       32'h33,       32'h44,       32'd0,        1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1);
    vecs[7]  = mk(32'h12345037, 32'h8000001C, 32'h55,       32'h66,       32'd0,        32'h12345000, 32'h12345000, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    vecs[8]  = mk(32'h00001097, 32'h80000010, 32'h1,        32'h2,        32'h80000010, 32'h1000,     32'h1000,     1, 3'd0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    vecs[9]  = mk(32'h008000EF, 32'h80000020, 32'h1,        32'h2,        32'h80000020, 32'd8,        32'd8,        1, 3'd0, 0, 1, 2, 0, 0, 0, 0, 3'd0, 1, 0, 0);
    vecs[10] = mk(32'h000080E7, 32'h80000024, 32'h80001000, 32'h2,        32'h80001000, 32'd0,        32'd0,        1, 3'd0, 0, 1, 2, 0, 0, 0, 0, 3'd0, 1, 1, 0);
    vecs[11] = mk(32'h00412183, 32'h80000028, 32'h100,      32'h2,        32'h100,      32'd4,        32'd4,        3, 3'd0, 0, 1, 1, 1, 0, 2, 0, 3'd0, 0, 0, 0);
    vecs[12] = mk(32'h00112423, 32'h8000002C, 32'h200,      32'hDEADBEEF, 32'h200,      32'd8,        32'd8,        8, 3'd0, 0, 0, 0, 0, 1, 2, 0, 3'd0, 0, 0, 0);

    rstn = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0;
    rf_rdata1 = '0; rf_rdata2 = '0; out_ready = 1'b1;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_alu_a", out_alu_a, 32'd0);
    check("rst_alu_b", out_alu_b, 32'd0);
    check("rst_ctrl", dut_ctrl(), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    rstn = 1'b1;

    // Back-to-back table, one instruction per cycle.
    for (int i = 0; i < 13; i++) apply(vecs[i], i);

    // Stall: entry v12 held while v0 is offered.
    @(negedge clock);
    out_ready = 1'b0;
    drive(vecs[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
      check_entry(vecs[12], $sformatf("stall%0d", c));
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    check_entry(vecs[0], "release");
    apply(vecs[1], 101);

    // Flush overrides a simultaneous accept.
    @(negedge clock);
    drive(vecs[2]);
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    check("flush_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    flush = 1'b0;
    #1;
    check("post_flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    check_entry(vecs[2], "post_flush");

    // Hold v2 then pull reset between clock edges.
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    check("hold_valid", 32'(out_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_alu_b", out_alu_b, 32'd0);
    @(negedge clock);
    rstn = 1'b1;
    out_ready = 1'b1;

    // Load one entry then drain with nothing behind it.
    apply(vecs[3], 103);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("drain_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
